// File: rtl/vcache_pkg.sv
// Shared types and geometry for the victim cache controller and its data ways.
package vcache_pkg;

   localparam int LINE_WIDTH     = 256;
   localparam int OFFSET_BITS    = 5;
   localparam int BYTES_PER_LINE = LINE_WIDTH / 8;
   localparam int DEF_TAG_WIDTH  = 27;
   localparam int DEF_NUM_WAYS   = 4;

   typedef enum logic [2:0] {
      IDLE,
      HIT,
      MEMRD,
      RESP,
      WB,
      FILL
   } state_e;

endpackage

// File: rtl/vcache_data_array.sv
// One victim-cache line: combinational read, byte-enabled synchronous write.
module vcache_data_array
   import vcache_pkg::*;
(
   input  logic                      clk_i,
   input  logic [BYTES_PER_LINE-1:0] be_i,
   input  logic [LINE_WIDTH-1:0]     din_i,
   output logic [LINE_WIDTH-1:0]     dout_o
);

   logic [LINE_WIDTH-1:0] mem_q;

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < BYTES_PER_LINE; b++) begin
         if (be_i[b]) begin
            mem_q[8*b +: 8] <= din_i[8*b +: 8];
         end
      end
   end

   assign dout_o = mem_q;

endmodule

// File: rtl/vcache_control.sv
// Exclusive, fully-associative victim cache controller: absorbs L1 evictions,
// swaps hits back to L1, forwards misses and writes back dirty victims.
module vcache_control
   import vcache_pkg::*;
#(
   parameter int NUM_WAYS  = DEF_NUM_WAYS,
   parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vc_read,
   input  logic                  vc_write,
   input  logic [31:0]           vc_address,
   input  logic [LINE_WIDTH-1:0] vc_wdata,
   input  logic                  vc_dirty,
   output logic [LINE_WIDTH-1:0] vc_rdata,
   output logic                  vc_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [31:0]           mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   localparam int WAY_W = $clog2(NUM_WAYS);

   state_e                state_q;
   logic [NUM_WAYS-1:0]   valid_q;
   logic [NUM_WAYS-1:0]   dirty_q;
   logic [WAY_W-1:0]      rr_ptr_q;
   logic [WAY_W-1:0]      way_q;
   logic                  repl_q;
   logic [TAG_WIDTH-1:0]  tag_q [NUM_WAYS];

   logic [TAG_WIDTH-1:0]  req_tag_q;
   logic [LINE_WIDTH-1:0] wdata_q;
   logic                  wdirty_q;

   logic                  vc_resp_q;
   logic [LINE_WIDTH-1:0] vc_rdata_q;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic [31:0]           mem_address_q;
   logic [LINE_WIDTH-1:0] mem_wdata_q;

   logic [TAG_WIDTH-1:0]  req_tag;
   logic                  hit;
   logic [WAY_W-1:0]      hit_way;
   logic                  free;
   logic [WAY_W-1:0]      free_way;
   logic [WAY_W-1:0]      victim;
   logic [LINE_WIDTH-1:0] way_data [NUM_WAYS];
   logic                  unused_offset;

   assign req_tag       = vc_address[OFFSET_BITS +: TAG_WIDTH];
   assign unused_offset = ^vc_address[OFFSET_BITS-1:0];

   // Descending scan so the lowest-index match / invalid way wins.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_q[w] && (tag_q[w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[w]) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   assign victim = free ? free_way : rr_ptr_q;

   for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
      logic [BYTES_PER_LINE-1:0] be;
      assign be = ((state_q == FILL) && (way_q == WAY_W'(g))) ? '1 : '0;

      vcache_data_array u_data (
         .clk_i  (clk),
         .be_i   (be),
         .din_i  (wdata_q),
         .dout_o (way_data[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         rr_ptr_q    <= '0;
         way_q       <= '0;
         repl_q      <= 1'b0;
         vc_resp_q   <= 1'b0;
         vc_rdata_q  <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               way_q  <= hit ? hit_way : victim;
               repl_q <= !hit && valid_q[victim];
               // Read wins when both are raised; the write must be re-presented.
               if (vc_read) begin
                  if (hit) begin
                     state_q    <= HIT;
                     vc_resp_q  <= 1'b1;
                     vc_rdata_q <= way_data[hit_way];
                  end else begin
                     state_q    <= MEMRD;
                     mem_read_q <= 1'b1;
                  end
               end else if (vc_write) begin
                  if (!hit && valid_q[victim] && dirty_q[victim]) begin
                     state_q     <= WB;
                     mem_write_q <= 1'b1;
                  end else begin
                     state_q   <= FILL;
                     vc_resp_q <= 1'b1;
                  end
               end
            end
            HIT: begin
               valid_q[way_q] <= 1'b0;
               dirty_q[way_q] <= 1'b0;
               vc_resp_q      <= 1'b0;
               vc_rdata_q     <= '0;
               state_q        <= IDLE;
            end
            MEMRD: begin
               if (mem_resp) begin
                  mem_read_q <= 1'b0;
                  vc_resp_q  <= 1'b1;
                  vc_rdata_q <= mem_rdata;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               vc_resp_q  <= 1'b0;
               vc_rdata_q <= '0;
               state_q    <= IDLE;
            end
            WB: begin
               if (mem_resp) begin
                  mem_write_q <= 1'b0;
                  vc_resp_q   <= 1'b1;
                  state_q     <= FILL;
               end
            end
            FILL: begin
               valid_q[way_q] <= 1'b1;
               dirty_q[way_q] <= wdirty_q;
               if (repl_q) begin
                  rr_ptr_q <= rr_ptr_q + 1'b1;
               end
               vc_resp_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Request and writeback payload are captured once in IDLE; tags follow the fill.
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && (vc_read || vc_write)) begin
         req_tag_q     <= req_tag;
         wdata_q       <= vc_wdata;
         wdirty_q      <= vc_dirty;
         mem_address_q <= vc_read ? 32'({req_tag, {OFFSET_BITS{1'b0}}})
                                  : 32'({tag_q[victim], {OFFSET_BITS{1'b0}}});
         mem_wdata_q   <= way_data[victim];
      end
      if (state_q == FILL) begin
         tag_q[way_q] <= req_tag_q;
      end
   end

   assign vc_resp     = vc_resp_q;
   assign vc_rdata    = vc_rdata_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_vcache_control.sv
// Scoreboard bench for vcache_control: directed requests, a 5-cycle memory model.
module tb_vcache_control;
   import vcache_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         vc_read;
   logic         vc_write;
   logic [31:0]  vc_address;
   logic [255:0] vc_wdata;
   logic         vc_dirty;
   logic [255:0] vc_rdata;
   logic         vc_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;

   typedef struct {
      bit           is_read;
      logic [255:0] rdata;
      int           lat;
      int           start;
   } resp_t;

   typedef struct {
      bit           is_write;
      logic [31:0]  addr;
      logic [255:0] data;
      bit           noresp;
   } mem_t;

   resp_t exp_resp[$];
   mem_t  exp_mem[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;

   localparam logic [255:0] L_A  = {8{32'hA000_0001}};
   localparam logic [255:0] L_B  = {8{32'hB000_0002}};
   localparam logic [255:0] L_C  = {8{32'hC000_0003}};
   localparam logic [255:0] L_D  = {8{32'hD000_0004}};
   localparam logic [255:0] L_A2 = {8{32'hA2A2_1111}};
   localparam logic [255:0] L_G  = {8{32'h6060_7777}};
   localparam logic [255:0] L_E  = {8{32'hE000_5555}};
   localparam logic [255:0] L_H  = {8{32'h8888_0008}};
   localparam logic [255:0] L_I  = {8{32'h1A1A_000A}};
   localparam logic [255:0] L_F  = {8{32'hF000_6666}};
   localparam logic [255:0] L_F2 = {8{32'hF2F2_6262}};
   localparam logic [255:0] L_E2 = {8{32'hE2E2_5252}};
   localparam logic [255:0] L_X  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] M1   = {8{32'h0123_4567}};
   localparam logic [255:0] M2   = {8{32'h89AB_CDEF}};
   localparam logic [255:0] M3   = {8{32'h5A5A_A5A5}};

   vcache_control dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vc_read     (vc_read),
      .vc_write    (vc_write),
      .vc_address  (vc_address),
      .vc_wdata    (vc_wdata),
      .vc_dirty    (vc_dirty),
      .vc_rdata    (vc_rdata),
      .vc_resp     (vc_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   // Response monitor: pops one expectation per vc_resp cycle.
   always @(negedge clk) begin
      if (rst_n && vc_resp) begin
         if (exp_resp.size() == 0) begin
            chk("unexpected_vc_resp", 1, 0);
         end else begin
            resp_t r;
            r = exp_resp.pop_front();
            chk("resp_latency", 256'(cyc - r.start), 256'(r.lat));
            if (r.is_read) chk("vc_rdata", vc_rdata, r.rdata);
         end
      end
   end

   // Memory model: checks each request, answers mem_resp five cycles after it appears.
   initial begin
      mem_t e;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && (mem_read || mem_write)) begin
            chk("mem_rd_wr_exclusive", 256'(mem_read && mem_write), 0);
            if (exp_mem.size() == 0) begin
               chk("unexpected_mem_req", 1, 0);
               e = '{mem_write, mem_address, '0, 1'b0};
            end else begin
               e = exp_mem.pop_front();
               chk("mem_req_is_write", 256'(mem_write), 256'(e.is_write));
               chk("mem_address", 256'(mem_address), 256'(e.addr));
               if (e.is_write) chk("mem_wdata", mem_wdata, e.data);
            end
            if (e.noresp) begin
               @(negedge rst_n);
            end else begin
               repeat (4) @(posedge clk);
               #1;
               chk("mem_req_held", 256'(e.is_write ? mem_write : mem_read), 1);
               mem_resp  = 1'b1;
               mem_rdata = e.is_write ? '0 : e.data;
               @(posedge clk);
               #1;
               mem_resp  = 1'b0;
               mem_rdata = '0;
            end
         end
      end
   end

   // Issue one request just after a clock edge and wait (bounded) for its vc_resp.
   task automatic req(input bit rd, input logic [31:0] a, input logic [255:0] wd,
                      input bit dty, input logic [255:0] exp_rd, input int lat);
      bit got;
      exp_resp.push_back('{rd, exp_rd, lat, cyc});
      vc_read    = rd;
      vc_write   = !rd;
      vc_address = a;
      vc_wdata   = wd;
      vc_dirty   = dty;
      got        = 1'b0;
      @(posedge clk);
      #1;
      vc_address = a ^ 32'hFFFF_001F;
      vc_wdata   = ~wd;
      vc_dirty   = !dty;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (vc_resp) got = 1'b1;
      end
      if (!got) begin
         chk("resp_timeout", 0, 1);
         void'(exp_resp.pop_front());
      end
      @(posedge clk);
      #1;
      vc_read  = 1'b0;
      vc_write = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      vc_read    = 1'b0;
      vc_write   = 1'b0;
      vc_address = '0;
      vc_wdata   = '0;
      vc_dirty   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vc_resp", 256'(vc_resp), 0);
      chk("rst_mem_read", 256'(mem_read), 0);
      chk("rst_mem_write", 256'(mem_write), 0);
      chk("rst_vc_rdata", vc_rdata, 0);
      chk("rst_valid", 256'(dut.valid_q), 0);
      chk("rst_rr_ptr", 256'(dut.rr_ptr_q), 0);
      chk("rst_state", 256'(dut.state_q), 256'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill all four free ways with clean lines.
      req(0, 32'h0000_1000, L_A, 0, '0, 1);
      req(0, 32'h0000_2000, L_B, 0, '0, 1);
      req(0, 32'h0000_3000, L_C, 0, '0, 1);
      req(0, 32'h0000_4000, L_D, 0, '0, 1);
      chk("fill_valid", 256'(dut.valid_q), 256'(4'b1111));
      chk("fill_dirty", 256'(dut.dirty_q), 0);
      chk("fill_rr_ptr", 256'(dut.rr_ptr_q), 0);

      // Swap out on a hit, then the same line misses.
      req(1, 32'h0000_2000, '0, 0, L_B, 1);
      chk("swap_valid", 256'(dut.valid_q), 256'(4'b1101));
      exp_mem.push_back('{1'b0, 32'h0000_2000, M1, 1'b0});
      req(1, 32'h0000_2000, '0, 0, M1, 6);
      chk("miss_no_alloc", 256'(dut.valid_q), 256'(4'b1101));

      exp_mem.push_back('{1'b0, 32'h0000_9000, M2, 1'b0});
      req(1, 32'h0000_9000, '0, 0, M2, 6);
      chk("miss_valid_kept", 256'(dut.valid_q), 256'(4'b1101));
      chk("miss_tag0_kept", 256'(dut.tag_q[0]), 256'(27'h80));

      // A stray memory response in IDLE must be ignored.
      mem_resp = 1'b1;
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      @(posedge clk);
      #1;
      chk("stray_mem_resp_state", 256'(dut.state_q), 256'(IDLE));

      // Dirty eviction of way 0 through a writeback.
      req(0, 32'h0000_1000, L_A2, 1, '0, 1);
      chk("wr_hit_dirty", 256'(dut.dirty_q), 256'(4'b0001));
      req(0, 32'h0000_7000, L_G, 0, '0, 1);
      chk("full_valid", 256'(dut.valid_q), 256'(4'b1111));
      chk("full_rr_ptr", 256'(dut.rr_ptr_q), 0);
      exp_mem.push_back('{1'b1, 32'h0000_1000, L_A2, 1'b0});
      req(0, 32'h0000_5000, L_E, 0, '0, 6);
      chk("wb_tag0", 256'(dut.tag_q[0]), 256'(27'h280));
      chk("wb_rr_ptr", 256'(dut.rr_ptr_q), 1);
      chk("wb_dirty", 256'(dut.dirty_q), 0);

      // Clean replacements walk rr_ptr to 3 and wrap it.
      req(0, 32'h0000_8000, L_H, 0, '0, 1);
      chk("rr_ptr_2", 256'(dut.rr_ptr_q), 2);
      req(0, 32'h0000_A000, L_I, 0, '0, 1);
      chk("rr_ptr_3", 256'(dut.rr_ptr_q), 3);
      req(0, 32'h0000_6000, L_F, 0, '0, 1);
      chk("wrap_rr_ptr", 256'(dut.rr_ptr_q), 0);
      chk("wrap_tag3", 256'(dut.tag_q[3]), 256'(27'h300));
      req(1, 32'h0000_6000, '0, 0, L_F, 1);
      chk("wrap_hit_valid", 256'(dut.valid_q), 256'(4'b0111));

      // Reset in the middle of a writeback.
      req(0, 32'h0000_6000, L_F2, 1, '0, 1);
      req(0, 32'h0000_5000, L_E2, 1, '0, 1);
      chk("pre_rst_dirty", 256'(dut.dirty_q), 256'(4'b1001));
      exp_mem.push_back('{1'b1, 32'h0000_5000, L_E2, 1'b1});
      vc_write   = 1'b1;
      vc_address = 32'h0000_D000;
      vc_wdata   = L_X;
      vc_dirty   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_wb_mem_write", 256'(mem_write), 1);
      chk("mid_wb_state", 256'(dut.state_q), 256'(WB));
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_write", 256'(mem_write), 0);
      chk("async_rst_state", 256'(dut.state_q), 256'(IDLE));
      chk("async_rst_valid", 256'(dut.valid_q), 0);
      chk("async_rst_rr_ptr", 256'(dut.rr_ptr_q), 0);
      vc_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_mem.push_back('{1'b0, 32'h0000_5000, M3, 1'b0});
      req(1, 32'h0000_5000, '0, 0, M3, 6);

      repeat (5) @(posedge clk);
      chk("resp_queue_drained", 256'(exp_resp.size()), 0);
      chk("mem_queue_drained", 256'(exp_mem.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vcache_control.md
Name: vcache_control

Overview:
- Controller for the 4-entry fully-associative, exclusive victim cache between L1 and the L2/memory port.
- Owns the tag/valid/dirty state and sequences NUM_WAYS instances of vcache_data_array.
- Behaviour by request type:
  - L1 evictions are absorbed into the victim cache.
  - L1 misses that hit are served and invalidated (swap).
  - Misses are forwarded to memory.
  - Dirty victims are written back before replacement.

Parameters:
- NUM_WAYS, 4, number of victim entries; power of two, at least 2.
- TAG_WIDTH, 27, line address bits, address[31:5].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- vc_read  in  1  L1 miss fill request; held until vc_resp.
- vc_write  in  1  L1 eviction request; held until vc_resp.
- vc_address  in  32  line address; bits [4:0] ignored.
- vc_wdata  in  256  evicted line.
- vc_dirty  in  1  evicted line is dirty.
- vc_rdata  out  256  returned line; valid while vc_resp=1.
- vc_resp  out  1  one-cycle completion pulse.
- mem_read  out  1  memory line read.
- mem_write  out  1  memory line write.
- mem_address  out  32  line address, bits [4:0]=0.
- mem_wdata  out  256  writeback line.
- mem_rdata  in  256  memory read line.
- mem_resp  in  1  memory completion pulse.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE, all valid=0, all dirty=0, rr_ptr=0.
  - vc_resp, mem_read and mem_write go to 0; vc_rdata=0.
  - Data array contents are not reset.
- Hit detection: way w hits when valid[w] and tag[w]==vc_address[31:5]. At most one way may hit; a tag is never stored twice.
- Free-way and victim selection:
  - free_way = lowest-index invalid way.
  - victim = free_way if one exists, else rr_ptr.
  - rr_ptr increments (wrapping NUM_WAYS-1 to 0) only when a valid entry is replaced.
- States:
  - IDLE: sample requests. vc_read takes priority if both are asserted (protocol violation; the write is ignored until re-presented).
    - Read hit: HIT.
    - Read miss: MEMRD.
    - Write hitting a tag: FILL into that way.
    - Write, no hit, victim invalid or clean: FILL.
    - Write, no hit, victim valid and dirty: WB.
  - HIT: vc_rdata=way data, vc_resp=1, valid[w]<=0, dirty[w]<=0. Go to IDLE. A read hit completes 1 cycle after the request is first seen.
  - MEMRD:
    - Drive mem_read=1 and mem_address=latched address; hold until mem_resp.
    - On mem_resp, register mem_rdata and go to RESP.
    - The victim cache is not allocated on a read miss.
  - RESP: vc_resp=1, vc_rdata=registered line, go to IDLE. vc_resp occurs the cycle after mem_resp.
  - WB:
    - Drive mem_write=1, mem_address={tag[victim],5'b0} and mem_wdata=victim data; hold until mem_resp.
    - On mem_resp go to FILL.
  - FILL:
    - All 32 byte-enables of the target way =1, datain=vc_wdata.
    - tag<=vc_address[31:5], valid<=1, dirty<=vc_dirty.
    - Update rr_ptr per the rule above. vc_resp=1, go to IDLE.
    - A write with a free or clean victim completes 1 cycle after the request.
- Every vc_resp is exactly one cycle. The requester deasserts in the same cycle, so IDLE never re-samples the completed request.
- mem_read and mem_write are never asserted together. Neither is asserted in IDLE, HIT, RESP or FILL.
- Request address and data are latched in IDLE; later input changes before vc_resp are ignored.
- mem_resp outside MEMRD or WB is ignored.

Decomposition:
- vcache_pkg:
  - state enum {IDLE, HIT, MEMRD, RESP, WB, FILL}.
  - LINE_WIDTH=256, OFFSET_BITS=5, BYTES_PER_LINE=32.
  - Default TAG_WIDTH.
- Sub-module: vcache_data_array, instantiated NUM_WAYS times via generate. The data array is combinational-read, byte-enable write.
- Tag, valid and dirty registers, rr_ptr and the FSM live in vcache_control.

Test Plan:
- Fill free ways: four writes to 0x1000, 0x2000, 0x3000, 0x4000, all clean.
  - Each completes with vc_resp 1 cycle after the request.
  - valid=4'b1111, rr_ptr=0, no mem traffic.
- Read hit swap: read 0x2000 after the fill above.
  - vc_resp 1 cycle later with vc_rdata equal to the stored line.
  - Way 1 invalidated; a re-read of 0x2000 goes to MEMRD.
- Read miss: read 0x9000.
  - mem_read=1 with mem_address=0x9000 until mem_resp (memory delay 5 cycles).
  - vc_resp the cycle after mem_resp with vc_rdata=mem_rdata.
  - Victim contents unchanged.
- Dirty eviction: full cache, way 0 (0x1000) dirty, rr_ptr=0; write 0x5000.
  - mem_write with mem_address=0x1000 and mem_wdata equal to the old line.
  - After mem_resp: FILL, vc_resp, way 0 tag=0x5000>>5, rr_ptr=1.
- Clean eviction and wrap: with rr_ptr=3 and all ways clean, write 0x6000.
  - No mem traffic; way 3 replaced; rr_ptr wraps to 0.
- Reset mid-writeback: assert rst_n=0 while mem_write=1.
  - mem_write drops immediately; state=IDLE; valid=0.
  - After release, read 0x5000 misses to memory.
